// File: rtl/pcm_tone_meter.sv
// pcm_tone_meter: measures a stereo PCM test tone over a window of
// 2^WIN_LOG2 samples. It reports per-channel peak magnitude, the count of
// positive-going crossings on the left channel, and the span in samples
// between the first and last crossing.
// Build option: define PCM_TONE_METER_LR_CHECK_EN to build the left/right
// equality checker; otherwise lr_mismatch is tied low.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for start; samples dropped
// S_ARM     | waiting for the first left crossing; times out as no_tone
// S_MEASURE | window running, sample index 1 .. 2^WIN_LOG2-1
// S_REPORT  | one cycle: publish working values, pulse done
module pcm_tone_meter #(
    parameter int DW       = 32,
    parameter int WIN_LOG2 = 12,
    parameter int ZC_W     = 16
) (
    input  logic                 mclk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 pcm_valid,
    input  logic signed [DW-1:0] pcml_in,
    input  logic signed [DW-1:0] pcmr_in,
    output logic                 busy,
    output logic                 done,
    output logic                 no_tone,
    output logic [DW-1:0]        peak_l,
    output logic [DW-1:0]        peak_r,
    output logic [ZC_W-1:0]      zc_count,
    output logic [ZC_W-1:0]      zc_span,
    output logic                 lr_mismatch
);

    localparam int CW = WIN_LOG2 + 1;
    localparam int XW = (CW > ZC_W) ? CW : ZC_W;
    localparam logic [CW-1:0] WIN_FULL = CW'(1 << WIN_LOG2);
    localparam logic [CW-1:0] WIN_LAST = CW'((1 << WIN_LOG2) - 1);
    localparam logic [XW-1:0] ZC_MAX_X = XW'({ZC_W{1'b1}});

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEASURE, S_REPORT} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [DW-1:0]      pk_l_q, pk_l_d, pk_r_q, pk_r_d;
    logic [ZC_W-1:0]    zc_q, zc_d, span_q, span_d;
    logic               nt_q, nt_d;
    logic signed [DW-1:0] prev_q, prev_d;

    logic [DW-1:0]      mag_l, mag_r;
    logic               crossing;
    logic [ZC_W-1:0]    zc_inc, span_val;
    logic [XW-1:0]      cnt_x;

    // magnitudes stay in DW bits; the most negative code maps to 2^(DW-1)
    assign mag_l    = pcml_in[DW-1] ? $unsigned(-pcml_in) : $unsigned(pcml_in);
    assign mag_r    = pcmr_in[DW-1] ? $unsigned(-pcmr_in) : $unsigned(pcmr_in);
    assign crossing = prev_q[DW-1] && !pcml_in[DW-1];
    assign zc_inc   = (zc_q == {ZC_W{1'b1}}) ? zc_q : zc_q + ZC_W'(1);
    assign cnt_x    = XW'(cnt_q);
    assign span_val = (cnt_x > ZC_MAX_X) ? {ZC_W{1'b1}} : cnt_x[ZC_W-1:0];
    assign busy     = (state_q != S_IDLE);

    // next-state and working accumulators
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pk_l_d  = pk_l_q;
        pk_r_d  = pk_r_q;
        zc_d    = zc_q;
        span_d  = span_q;
        nt_d    = nt_q;
        prev_d  = prev_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ARM;
                    cnt_d   = '0;
                    pk_l_d  = '0;
                    pk_r_d  = '0;
                    zc_d    = '0;
                    span_d  = '0;
                    nt_d    = 1'b0;
                    prev_d  = '0;
                end
            end
            S_ARM: begin
                if (pcm_valid) begin
                    prev_d = pcml_in;
                    if (crossing) begin
                        state_d = S_MEASURE;
                        cnt_d   = CW'(1);
                        zc_d    = ZC_W'(1);
                        pk_l_d  = mag_l;
                        pk_r_d  = mag_r;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q + CW'(1) == WIN_FULL) begin
                            state_d = S_REPORT;
                            nt_d    = 1'b1;
                        end
                    end
                end
            end
            S_MEASURE: begin
                if (pcm_valid) begin
                    prev_d = pcml_in;
                    pk_l_d = (mag_l > pk_l_q) ? mag_l : pk_l_q;
                    pk_r_d = (mag_r > pk_r_q) ? mag_r : pk_r_q;
                    if (crossing) begin
                        zc_d   = zc_inc;
                        span_d = span_val;
                    end
                    if (cnt_q == WIN_LAST) state_d = S_REPORT;
                    else                   cnt_d   = cnt_q + CW'(1);
                end
            end
            S_REPORT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // state and working registers
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pk_l_q  <= '0;
            pk_r_q  <= '0;
            zc_q    <= '0;
            span_q  <= '0;
            nt_q    <= 1'b0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pk_l_q  <= pk_l_d;
            pk_r_q  <= pk_r_d;
            zc_q    <= zc_d;
            span_q  <= span_d;
            nt_q    <= nt_d;
            prev_q  <= prev_d;
        end
    end

    // published results, held until the next report
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            done     <= 1'b0;
            no_tone  <= 1'b0;
            peak_l   <= '0;
            peak_r   <= '0;
            zc_count <= '0;
            zc_span  <= '0;
        end else begin
            done <= (state_q == S_REPORT);
            if (state_q == S_REPORT) begin
                no_tone  <= nt_q;
                peak_l   <= pk_l_q;
                peak_r   <= pk_r_q;
                zc_count <= zc_q;
                zc_span  <= span_q;
            end
        end
    end

`ifdef PCM_TONE_METER_LR_CHECK_EN
    logic mm_q, mm_d;

    // sticky left/right inequality flag over the measured window
    always_comb begin
        mm_d = mm_q;
        if (state_q == S_IDLE && start)
            mm_d = 1'b0;
        else if (state_q == S_MEASURE && pcm_valid && (pcml_in != pcmr_in))
            mm_d = 1'b1;
    end

    // flag register and its published copy
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            mm_q        <= 1'b0;
            lr_mismatch <= 1'b0;
        end else begin
            mm_q <= mm_d;
            if (state_q == S_REPORT) lr_mismatch <= mm_q;
        end
    end
`else
    assign lr_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_pcm_tone_meter.sv
// Scoreboard bench for pcm_tone_meter with a 64-sample window.
module tb_pcm_tone_meter;

    localparam int DW  = 32;
    localparam int WL  = 6;
    localparam int ZW  = 16;
    localparam int WIN = 1 << WL;

    logic                 mclk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 start = 1'b0;
    logic                 pcm_valid = 1'b0;
    logic signed [DW-1:0] pcml_in = '0;
    logic signed [DW-1:0] pcmr_in = '0;
    logic                 busy, done, no_tone, lr_mismatch;
    logic [DW-1:0]        peak_l, peak_r;
    logic [ZW-1:0]        zc_count, zc_span;

    pcm_tone_meter #(.DW(DW), .WIN_LOG2(WL), .ZC_W(ZW)) dut (
        .mclk(mclk), .reset_n(reset_n), .start(start), .pcm_valid(pcm_valid),
        .pcml_in(pcml_in), .pcmr_in(pcmr_in), .busy(busy), .done(done),
        .no_tone(no_tone), .peak_l(peak_l), .peak_r(peak_r),
        .zc_count(zc_count), .zc_span(zc_span), .lr_mismatch(lr_mismatch)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic [31:0] pl;
        logic [31:0] pr;
        logic [15:0] zc;
        logic [15:0] span;
        logic        nt;
        logic        mm;
        int          gap;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   sl[0:511];
    int   sr[0:511];
    int   cyc = 0;
    int   last_done = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference: scan the stream from the first ARM sample s, push expectation
    task automatic model_meas(input int s, input bit gap_en, output int n);
        exp_t e;
        int   prev, x, c0;
        bit   found, mmf;
        longint m;
        e = '{default: 0};
        prev = 0; found = 0; c0 = 0; mmf = 0;
        for (int i = 0; i < WIN; i++) begin
            x = sl[s + i];
            if (prev < 0 && x >= 0) begin
                found = 1;
                c0 = s + i;
                break;
            end
            prev = x;
        end
        if (!found) begin
            e.nt = 1'b1;
            n = WIN;
        end else begin
            for (int j = 0; j < WIN; j++) begin
                x = sl[c0 + j];
                if (prev < 0 && x >= 0) begin
                    if (e.zc != 16'hffff) e.zc = e.zc + 16'd1;
                    e.span = 16'(j);
                end
                m = (x < 0) ? -longint'(x) : longint'(x);
                if (m > longint'(e.pl)) e.pl = m[31:0];
                m = (sr[c0 + j] < 0) ? -longint'(sr[c0 + j]) : longint'(sr[c0 + j]);
                if (m > longint'(e.pr)) e.pr = m[31:0];
                if (j > 0 && sr[c0 + j] != x) mmf = 1;
                prev = x;
            end
            n = (c0 - s) + WIN;
`ifdef PCM_TONE_METER_LR_CHECK_EN
            e.mm = mmf;
`endif
        end
        e.gap = gap_en ? n + 2 : 0;
        sb.push_back(e);
    endtask

    task automatic fill_square();
        for (int i = 0; i < 512; i++) begin
            sl[i] = ((i % 8) < 4) ? -1000 : 1000;
            sr[i] = sl[i];
        end
    endtask

    task automatic send(input int l, input int r, input int sp);
        @(negedge mclk);
        pcm_valid = 1'b1;
        pcml_in   = l;
        pcmr_in   = r;
        repeat (sp - 1) begin
            @(negedge mclk);
            pcm_valid = 1'b0;
        end
    endtask

    task automatic run_stream(input int s, input int n, input int sp);
        for (int i = 0; i < n; i++) send(sl[s + i], sr[s + i], sp);
        @(negedge mclk);
        pcm_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge mclk);
        start = 1'b1;
        @(negedge mclk);
        start = 1'b0;
    endtask

    task automatic wait_sb(input int limit);
        int t;
        t = 0;
        while (sb.size() != 0 && t < limit) begin
            @(negedge mclk);
            t++;
        end
        check("sb_drain", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge mclk);
    endtask

    task automatic check_zero_outputs(input string pfx);
        check({pfx, "_busy"}, 64'(busy), 64'd0);
        check({pfx, "_done"}, 64'(done), 64'd0);
        check({pfx, "_no_tone"}, 64'(no_tone), 64'd0);
        check({pfx, "_peak_l"}, 64'(peak_l), 64'd0);
        check({pfx, "_peak_r"}, 64'(peak_r), 64'd0);
        check({pfx, "_zc_count"}, 64'(zc_count), 64'd0);
        check({pfx, "_zc_span"}, 64'(zc_span), 64'd0);
        check({pfx, "_lr"}, 64'(lr_mismatch), 64'd0);
    endtask

    always @(posedge mclk) cyc <= cyc + 1;

    // pop one expectation per done pulse and compare every result field
    always @(negedge mclk) begin
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("peak_l", 64'(peak_l), 64'(mon_e.pl));
                check("peak_r", 64'(peak_r), 64'(mon_e.pr));
                check("zc_count", 64'(zc_count), 64'(mon_e.zc));
                check("zc_span", 64'(zc_span), 64'(mon_e.span));
                check("no_tone", 64'(no_tone), 64'(mon_e.nt));
                check("lr_mismatch", 64'(lr_mismatch), 64'(mon_e.mm));
                if (mon_e.gap != 0) check("done_gap", 64'(cyc - last_done), 64'(mon_e.gap));
            end
            last_done = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n1, n2, n3, s2, s3, total;

        repeat (3) @(negedge mclk);
        check_zero_outputs("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge mclk);

        // square wave, sparse samples
        fill_square();
        pulse_start();
        model_meas(0, 0, n);
        run_stream(0, n, 16);
        wait_sb(400);
        check("sq_busy_after", 64'(busy), 64'd0);

        // constant positive level: no crossing, timeout
        for (int i = 0; i < 512; i++) begin sl[i] = 5; sr[i] = 5; end
        pulse_start();
        model_meas(0, 0, n);
        run_stream(0, n, 3);
        wait_sb(400);

        // full-scale codes on both channels
        fill_square();
        sl[10] = int'(32'h80000000);
        sr[13] = 32'sh7FFFFFFF;
        pulse_start();
        model_meas(0, 0, n);
        run_stream(0, n, 2);
        wait_sb(400);

        // right differs at window index 10, then an identical window
        fill_square();
        sr[14] = sl[14] + 1;
        pulse_start();
        model_meas(0, 0, n);
        run_stream(0, n, 1);
        wait_sb(400);
        fill_square();
        pulse_start();
        model_meas(0, 0, n);
        run_stream(0, n, 1);
        wait_sb(400);

        // reset at window index 30
        fill_square();
        pulse_start();
        run_stream(0, 4 + 31, 2);
        reset_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        repeat (3) begin
            @(negedge mclk);
            check("midrst_done_low", 64'(done), 64'd0);
        end
        reset_n = 1'b1;
        @(negedge mclk);
        pulse_start();
        model_meas(0, 0, n);
        run_stream(0, n, 4);
        wait_sb(600);

        // back-to-back with start held and a sample every cycle
        for (int i = 0; i < 512; i++) begin
            sl[i] = ((i % 8) < 4) ? -(100 + (i % 37) * 3) : (100 + (i % 37) * 3);
            sr[i] = ((i % 8) < 4) ? -(50 + (i % 11)) : (50 + (i % 11));
        end
        model_meas(0, 0, n1);
        s2 = n1 + 2;
        model_meas(s2, 1, n2);
        s3 = s2 + n2 + 2;
        model_meas(s3, 1, n3);
        total = s3 + n3;
        @(negedge mclk);
        start = 1'b1;
        for (int i = 0; i <= total + 1; i++) begin
            @(negedge mclk);
            pcm_valid = 1'b1;
            pcml_in   = sl[i];
            pcmr_in   = sr[i];
            if (i == total) start = 1'b0;
        end
        @(negedge mclk);
        pcm_valid = 1'b0;
        wait_sb(400);
        check("b2b_idle_after", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
